// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter
// Owns the single framebuffer BRAM port and shares it between the VGA
// scan-out fetch (strict priority, never stalled) and the matrix-multiply
// result writer. Writer words are queued in a small FIFO and drained into
// cycles the display does not use.
//
// Build option: define WR_BLANK_ONLY_EN to restrict drains to blanking
// intervals. Default build (undefined) drains in any cycle without disp_req.
module fb_access_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          blank,
  input  logic                          disp_req,
  input  logic [ADDR_W-1:0]             disp_addr,
  output logic                          disp_rvalid,
  output logic [DATA_W-1:0]             disp_rdata,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              conflict_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // State names which requester owns the BRAM port in the following cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DISP  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;

  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;

  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                rvalid_q, rvalid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                not_empty_s;
  logic                drain_ok_s;
  logic                blocked_s;
  logic                push_s;
  logic                pop_s;

  // FIFO occupancy, drain permission and conflict qualification.
  always_comb begin
    not_empty_s = (level_q != {LVL_W{1'b0}});
    push_s      = wr_valid & wr_ready;
`ifdef WR_BLANK_ONLY_EN
    drain_ok_s  = ~disp_req & not_empty_s & blank;
    blocked_s   = not_empty_s & (disp_req | ~blank);
`else
    drain_ok_s  = ~disp_req & not_empty_s;
    blocked_s   = not_empty_s & disp_req;
`endif
  end

  // Port-owner selection and the BRAM command for the next cycle.
  always_comb begin
    state_d     = ST_IDLE;
    pop_s       = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = {ADDR_W{1'b0}};
    mem_wdata_d = {DATA_W{1'b0}};
    if (disp_req) begin
      state_d    = ST_DISP;
      mem_en_d   = 1'b1;
      mem_addr_d = disp_addr;
    end else if (drain_ok_s) begin
      state_d     = ST_DRAIN;
      pop_s       = 1'b1;
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = fifo_addr_q[rd_ptr_q];
      mem_wdata_d = fifo_data_q[rd_ptr_q];
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Read data returns one cycle after a display read occupied the port.
  always_comb begin
    case (state_q)
      ST_DISP:  rvalid_d = 1'b1;
      ST_DRAIN: rvalid_d = 1'b0;
      ST_IDLE:  rvalid_d = 1'b0;
      default:  rvalid_d = 1'b0;
    endcase
  end

  // FIFO pointer/level bookkeeping; level only changes when push != pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      level_d = level_q + {{(LVL_W-1){1'b0}}, 1'b1};
    end else if (pop_s && !push_s) begin
      level_d = level_q - {{(LVL_W-1){1'b0}}, 1'b1};
    end else begin
      level_d = level_q;
    end
  end

  // Saturating conflict counter: holds at all-ones instead of wrapping.
  always_comb begin
    if (blocked_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Control and BRAM port registers; reset drops queued words and in-flight reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      level_q     <= {LVL_W{1'b0}};
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      rvalid_q    <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rvalid_q    <= rvalid_d;
      cnt_q       <= cnt_d;
    end
  end

  // FIFO storage; contents are only meaningful under the level count, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

  assign wr_ready     = (level_q != LVL_W'(FIFO_DEPTH));
  assign fifo_level   = level_q;
  assign conflict_cnt = cnt_q;
  assign disp_rvalid  = rvalid_q;
  assign disp_rdata   = mem_rdata;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Testbench for fb_access_arbiter: directed vector table, hand sequences
// for reset/latency/blank gating/saturation, and a randomized phase checked
// against a queue-based reference model.
module tb_fb_access_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        blank = 1'b1;
  logic        disp_req = 1'b0;
  logic [16:0] disp_addr = 17'd0;
  logic        disp_rvalid;
  logic [7:0]  disp_rdata;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [16:0] wr_addr = 17'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        mem_en, mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'd0;
  logic [2:0]  fifo_level;
  logic [15:0] conflict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fb_access_arbiter #(.ADDR_W(17), .DATA_W(8), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .blank(blank),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fifo_level(fifo_level), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct packed { logic [16:0] a; logic [7:0] d; } wr_t;
  wr_t         mq[$];
  logic        m_en, m_we, m_rv;
  logic [16:0] m_a;
  logic [7:0]  m_d;
  logic [15:0] m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_en = 1'b0; m_we = 1'b0; m_rv = 1'b0;
    m_a = 17'd0; m_d = 8'd0; m_cnt = 16'd0;
  endtask

  // One clock: drive inputs, advance the model on the edge, compare after it.
  task automatic step(input logic dr, input logic bl, input logic wv,
                      input logic [16:0] da, input logic [16:0] wa, input logic [7:0] wd);
    int  lvl;
    logic rdy, blocked, drain, nrv;
    wr_t e;
    disp_req = dr; blank = bl; wr_valid = wv;
    disp_addr = da; wr_addr = wa; wr_data = wd;
    mem_rdata = 8'($urandom);
    @(posedge clk);
    lvl = mq.size();
    rdy = (lvl < 4);
    nrv = m_en & ~m_we;
`ifdef WR_BLANK_ONLY_EN
    blocked = (lvl != 0) && (dr || !bl);
    drain   = !dr && (lvl != 0) && bl;
`else
    blocked = (lvl != 0) && dr;
    drain   = !dr && (lvl != 0);
`endif
    if (dr) begin
      m_en = 1'b1; m_we = 1'b0; m_a = da; m_d = 8'd0;
    end else if (drain) begin
      e = mq.pop_front();
      m_en = 1'b1; m_we = 1'b1; m_a = e.a; m_d = e.d;
    end else begin
      m_en = 1'b0; m_we = 1'b0; m_a = 17'd0; m_d = 8'd0;
    end
    if (wv && rdy) mq.push_back('{a: wa, d: wd});
    if (blocked && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_rv = nrv;
    #1;
    chk("mdl_mem_en",    32'(mem_en),       32'(m_en));
    chk("mdl_mem_we",    32'(mem_we),       32'(m_we));
    chk("mdl_mem_addr",  32'(mem_addr),     32'(m_a));
    chk("mdl_mem_wdata", 32'(mem_wdata),    32'(m_d));
    chk("mdl_rvalid",    32'(disp_rvalid),  32'(m_rv));
    chk("mdl_level",     32'(fifo_level),   32'(mq.size()));
    chk("mdl_wr_ready",  32'(wr_ready),     32'(mq.size() < 4));
    chk("mdl_conflict",  32'(conflict_cnt), 32'(m_cnt));
    chk("mdl_rdata",     32'(disp_rdata),   32'(mem_rdata));
  endtask

  task automatic do_reset();
    @(negedge clk);
    disp_req = 1'b0; wr_valid = 1'b0; blank = 1'b1;
    reset_n = 1'b0;
    model_clear();
    #1;
    chk("rst_level",    32'(fifo_level),   32'd0);
    chk("rst_mem_en",   32'(mem_en),       32'd0);
    chk("rst_mem_we",   32'(mem_we),       32'd0);
    chk("rst_rvalid",   32'(disp_rvalid),  32'd0);
    chk("rst_wr_ready", 32'(wr_ready),     32'd1);
    chk("rst_conflict", 32'(conflict_cnt), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic dr, wv; logic [16:0] da, wa; logic [7:0] wd;
    logic en, we; logic [16:0] ma; logic [7:0] md; logic rv;
    logic [2:0] lvl; logic rdy; logic [15:0] cnt;
  } vec_t;
  vec_t tbl[14];

  initial begin
    int rv_cnt, first_rv, addr_bad, guard;
    // dr  wv  disp_addr  wr_addr    wd      en    we    mem_addr   wdata   rv    lvl   rdy   cnt
    tbl[0]  = '{1'b1,1'b1,17'h010,17'h100,8'hA1, 1'b1,1'b0,17'h010,8'h00, 1'b0,3'd1,1'b1,16'd0};
    tbl[1]  = '{1'b1,1'b1,17'h010,17'h101,8'hA2, 1'b1,1'b0,17'h010,8'h00, 1'b1,3'd2,1'b1,16'd1};
    tbl[2]  = '{1'b1,1'b1,17'h010,17'h102,8'hA3, 1'b1,1'b0,17'h010,8'h00, 1'b1,3'd3,1'b1,16'd2};
    tbl[3]  = '{1'b1,1'b1,17'h010,17'h103,8'hA4, 1'b1,1'b0,17'h010,8'h00, 1'b1,3'd4,1'b0,16'd3};
    tbl[4]  = '{1'b1,1'b1,17'h010,17'h104,8'hA5, 1'b1,1'b0,17'h010,8'h00, 1'b1,3'd4,1'b0,16'd4};
    tbl[5]  = '{1'b0,1'b0,17'h000,17'h000,8'h00, 1'b1,1'b1,17'h100,8'hA1, 1'b1,3'd3,1'b1,16'd4};
    tbl[6]  = '{1'b0,1'b0,17'h000,17'h000,8'h00, 1'b1,1'b1,17'h101,8'hA2, 1'b0,3'd2,1'b1,16'd4};
    tbl[7]  = '{1'b0,1'b1,17'h000,17'h105,8'hB1, 1'b1,1'b1,17'h102,8'hA3, 1'b0,3'd2,1'b1,16'd4};
    tbl[8]  = '{1'b0,1'b0,17'h000,17'h000,8'h00, 1'b1,1'b1,17'h103,8'hA4, 1'b0,3'd1,1'b1,16'd4};
    tbl[9]  = '{1'b0,1'b0,17'h000,17'h000,8'h00, 1'b1,1'b1,17'h105,8'hB1, 1'b0,3'd0,1'b1,16'd4};
    tbl[10] = '{1'b0,1'b0,17'h000,17'h000,8'h00, 1'b0,1'b0,17'h000,8'h00, 1'b0,3'd0,1'b1,16'd4};
    tbl[11] = '{1'b0,1'b1,17'h000,17'h1AB,8'hC7, 1'b0,1'b0,17'h000,8'h00, 1'b0,3'd1,1'b1,16'd4};
    tbl[12] = '{1'b0,1'b0,17'h000,17'h000,8'h00, 1'b1,1'b1,17'h1AB,8'hC7, 1'b0,3'd0,1'b1,16'd4};
    tbl[13] = '{1'b0,1'b0,17'h000,17'h000,8'h00, 1'b0,1'b0,17'h000,8'h00, 1'b0,3'd0,1'b1,16'd4};

    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("init_wr_ready", 32'(wr_ready),     32'd1);
    chk("init_mem_en",   32'(mem_en),       32'd0);
    chk("init_level",    32'(fifo_level),   32'd0);
    chk("init_conflict", 32'(conflict_cnt), 32'd0);

    // Buffering, ordering, simultaneous push/pop and no-bypass vectors
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].dr, 1'b1, tbl[i].wv, tbl[i].da, tbl[i].wa, tbl[i].wd);
      chk($sformatf("vec%0d_en", i),    32'(mem_en),       32'(tbl[i].en));
      chk($sformatf("vec%0d_we", i),    32'(mem_we),       32'(tbl[i].we));
      chk($sformatf("vec%0d_addr", i),  32'(mem_addr),     32'(tbl[i].ma));
      chk($sformatf("vec%0d_wdata", i), 32'(mem_wdata),    32'(tbl[i].md));
      chk($sformatf("vec%0d_rv", i),    32'(disp_rvalid),  32'(tbl[i].rv));
      chk($sformatf("vec%0d_lvl", i),   32'(fifo_level),   32'(tbl[i].lvl));
      chk($sformatf("vec%0d_rdy", i),   32'(wr_ready),     32'(tbl[i].rdy));
      chk($sformatf("vec%0d_cnt", i),   32'(conflict_cnt), 32'(tbl[i].cnt));
    end

    // Reset with three words queued: they must be discarded, no write issued
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 17'h020, 17'(17'h200 + i), 8'(8'h50 + i));
    chk("rstq_level", 32'(fifo_level), 32'd3);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 17'h000, 17'h000, 8'h00);
      chk("rstq_no_write", 32'(mem_en), 32'd0);
    end

    // Display latency over one full 640-pixel line
    rv_cnt = 0; first_rv = -1; addr_bad = 0;
    for (int i = 0; i < 644; i++) begin
      step(i < 640, 1'b0, 1'b0, 17'(i), 17'h000, 8'h00);
      if (i < 640 && (mem_addr !== 17'(i) || mem_en !== 1'b1 || mem_we !== 1'b0)) addr_bad++;
      if (disp_rvalid === 1'b1) begin
        rv_cnt++;
        if (first_rv < 0) first_rv = i;
      end
    end
    chk("lat_addr_errs", 32'(addr_bad), 32'd0);
    chk("lat_rv_count",  32'(rv_cnt),   32'd640);
    chk("lat_rv_first",  32'(first_rv), 32'd1);

    // Drain gating by blank
    do_reset();
    step(1'b0, 1'b0, 1'b1, 17'h000, 17'h0ABC, 8'h3C);
`ifdef WR_BLANK_ONLY_EN
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 17'h000, 17'h000, 8'h00);
      chk("blank_hold_we", 32'(mem_we), 32'd0);
    end
    chk("blank_hold_cnt", 32'(conflict_cnt), 32'd4);
    step(1'b0, 1'b1, 1'b0, 17'h000, 17'h000, 8'h00);
    chk("blank_rel_we",   32'(mem_we),   32'd1);
    chk("blank_rel_addr", 32'(mem_addr), 32'h0ABC);
`else
    step(1'b0, 1'b0, 1'b0, 17'h000, 17'h000, 8'h00);
    chk("active_drain_we",   32'(mem_we),   32'd1);
    chk("active_drain_addr", 32'(mem_addr), 32'h0ABC);
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 100) < 55, 1'($urandom), ($urandom % 100) < 50,
           17'($urandom), 17'($urandom), 8'($urandom));
    end

    // Saturation of conflict_cnt
    step(1'b1, 1'b1, 1'b1, 17'h001, 17'h1234, 8'h77);
    guard = 0;
    while (m_cnt < 16'hFFFE && guard < 70000) begin
      step(1'b1, 1'b1, 1'b0, 17'h001, 17'h000, 8'h00);
      guard++;
    end
    chk("sat_reach", 32'(conflict_cnt), 32'h0000FFFE);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 17'h001, 17'h000, 8'h00);
    chk("sat_hold", 32'(conflict_cnt), 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
